complex_dot_accum: RTL
======================

COMPLEX_DOT_ACCUM -- requirements
Module: complex_dot_accum

Interface
REQ-001 Parameter W, default 16: bit-width of the real/imaginary operands feeding the upstream complex multiplier.
REQ-002 Parameter N, default 4: number of complex products summed per dot-product result; legal range 2..256.
REQ-003 Derived localparam IW = 2*W+1: input part width, matching the complex multiplier output.
REQ-004 Derived localparam AW = IW + $clog2(N): accumulator and output part width.
REQ-005 clk  input  1: single clock; all state updates on the rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 in_valid  input  1: upstream product pair present.
REQ-008 in_ready  output  1: block accepts a product this cycle.
REQ-009 in_Cr  input  IW signed: real part of one complex product.
REQ-010 in_Ci  input  IW signed: imaginary part of one complex product.
REQ-011 out_valid  output  1: completed dot-product result held.
REQ-012 out_ready  input  1: downstream accepts the result this cycle.
REQ-013 out_Cr  output  AW signed: accumulated real sum.
REQ-014 out_Ci  output  AW signed: accumulated imaginary sum.
REQ-015 out_cnt  output  8: number of results accepted by downstream since reset, modulo 256.

Function
REQ-016 An input transfer SHALL occur on a cycle with in_valid && in_ready; an output transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-017 Term counter cnt (0..N-1) SHALL advance by one per input transfer, wrapping from N-1 to 0.
REQ-018 On a transfer with cnt==0, the accumulator SHALL load the sign-extended input; with cnt!=0 it SHALL load acc + sign-extended input, independently per part.
REQ-019 On a transfer with cnt==N-1, out_Cr/out_Ci SHALL load the final sum, out_valid SHALL be 1 next cycle, and the accumulator restarts at the next transfer: latency from the last input to the visible result is one cycle.
REQ-020 Arithmetic SHALL be two's complement at AW bits with no saturation or overflow; AW is sized so that N worst-case inputs cannot overflow.
REQ-021 in_ready SHALL be 0 only when cnt==N-1 && out_valid && !out_ready; otherwise it is 1, so the next vector accumulates while the previous result waits.
REQ-022 When an output transfer and a final-term load occur in the same cycle, the new result SHALL replace the old one and out_valid SHALL remain 1 with no bubble.
REQ-023 out_valid SHALL fall to 0 after an output transfer with no same-cycle final-term load.
REQ-024 out_Cr, out_Ci and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-025 out_cnt SHALL increment by one on each output transfer, wrapping from 255 to 0.
REQ-026 in_Cr/in_Ci SHALL be ignored on cycles with no input transfer.

Reset
REQ-027 While rst is high at a clock edge: cnt=0, accumulator=0, out_valid=0, out_Cr=0, out_Ci=0, out_cnt=0; in_ready reads 1 the cycle after.
REQ-028 Reset mid-vector SHALL discard the partial sum and any pending result; the first transfer after reset is term 0.
REQ-029 rst SHALL have priority over simultaneous input or output transfers.

Verification (W=4, N=4, IW=9, AW=11)
REQ-030 Inputs (1,2),(3,-4),(-5,6),(7,8) back-to-back with out_ready=1 -> one cycle after the 4th input: out_valid=1, out_Cr=6, out_Ci=12; out_cnt=1 after acceptance.
REQ-031 Four inputs (255,-256) -> out_Cr=1020, out_Ci=-1024 exactly, with no wrap.
REQ-032 Eight consecutive inputs, all (1,1), with out_ready=0 -> first result (4,4) held; in_ready=0 while cnt==3; raising out_ready for 1 cycle -> the 8th input is accepted in that cycle and the next cycle shows (4,4) again with no out_valid gap.
REQ-033 Continuous streaming of 3 vectors with out_ready=1 -> in_ready is never 0; three results appear at a 4-cycle spacing; out_cnt=3.
REQ-034 rst asserted after 2 of 4 terms, then 4 inputs (2,3) -> result (8,12); none of the discarded partial sum appears.
REQ-035 in_valid toggling randomly with out_ready randomly -> every result equals the reference model sum of its 4 accepted terms; no result is lost or duplicated.

Source files
------------

// File: rtl/complex_dot_accum_if.sv
// Handshake bundle between a complex-product source and the dot-product accumulator.
// Each transfer carries one complex product. Each result carries one accumulated complex sum.
interface complex_dot_accum_if #(
  parameter int W = 16,
  parameter int N = 4
);
  localparam int IW = 2 * W + 1;
  localparam int AW = IW + $clog2(N);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] in_Cr;
  logic signed [IW-1:0] in_Ci;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_Cr;
  logic signed [AW-1:0] out_Ci;
  logic [7:0]           out_cnt;

  modport master (
    output in_valid, in_Cr, in_Ci, out_ready,
    input  in_ready, out_valid, out_Cr, out_Ci, out_cnt
  );

  modport slave (
    input  in_valid, in_Cr, in_Ci, out_ready,
    output in_ready, out_valid, out_Cr, out_Ci, out_cnt
  );
endinterface

// File: rtl/complex_dot_accum.sv
// Sums N consecutive complex products into one complex result.
// The result is held in an output register that uses a valid/ready handshake.
module complex_dot_accum #(
  parameter int W = 16,
  parameter int N = 4
) (
  input logic                clk,
  input logic                rst,
  complex_dot_accum_if.slave bus
);
  localparam int IW = 2 * W + 1;
  localparam int AW = IW + $clog2(N);
  localparam int CW = $clog2(N);

  logic [CW-1:0]        cnt_r;
  logic signed [AW-1:0] acc_cr_r;
  logic signed [AW-1:0] acc_ci_r;
  logic signed [AW-1:0] out_cr_r;
  logic signed [AW-1:0] out_ci_r;
  logic                 out_valid_r;
  logic [7:0]           out_cnt_r;

  logic signed [AW-1:0] ext_cr_s;
  logic signed [AW-1:0] ext_ci_s;
  logic signed [AW-1:0] sum_cr_s;
  logic signed [AW-1:0] sum_ci_s;
  logic                 last_s;
  logic                 in_ready_s;
  logic                 in_xfer_s;
  logic                 out_xfer_s;

  // Decode the handshakes and form the next partial sums.
  always_comb begin
    ext_cr_s   = {{(AW-IW){bus.in_Cr[IW-1]}}, bus.in_Cr};
    ext_ci_s   = {{(AW-IW){bus.in_Ci[IW-1]}}, bus.in_Ci};
    last_s     = (cnt_r == CW'(N - 1));
    // Stall only the final term, and only while the previous result is still unclaimed.
    if (last_s && out_valid_r && !bus.out_ready) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = 1'b1;
    end
    in_xfer_s  = bus.in_valid && in_ready_s;
    out_xfer_s = out_valid_r && bus.out_ready;
    if (cnt_r == '0) begin
      sum_cr_s = ext_cr_s;
      sum_ci_s = ext_ci_s;
    end else begin
      sum_cr_s = acc_cr_r + ext_cr_s;
      sum_ci_s = acc_ci_r + ext_ci_s;
    end
  end

  // Update the term counter, the accumulator, the result register and the delivered-result count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= '0;
      acc_cr_r    <= '0;
      acc_ci_r    <= '0;
      out_cr_r    <= '0;
      out_ci_r    <= '0;
      out_valid_r <= 1'b0;
      out_cnt_r   <= 8'd0;
    end else begin
      if (in_xfer_s) begin
        acc_cr_r <= sum_cr_s;
        acc_ci_r <= sum_ci_s;
        if (last_s) begin
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
      // A new final sum takes priority, so the result register is overwritten with no bubble.
      if (in_xfer_s && last_s) begin
        out_cr_r    <= sum_cr_s;
        out_ci_r    <= sum_ci_s;
        out_valid_r <= 1'b1;
      end else if (out_xfer_s) begin
        out_valid_r <= 1'b0;
      end
      if (out_xfer_s) begin
        out_cnt_r <= out_cnt_r + 8'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_Cr    = out_cr_r;
  assign bus.out_Ci    = out_ci_r;
  assign bus.out_cnt   = out_cnt_r;
endmodule
